gradient_dram_write_responder: RTL and testbench
================================================

Name: gradient_dram_write_responder

Overview:
- Memory-side endpoint of the gradient writeback DRAM write channel (dram_valid/dram_addr/dram_value/dram_ready).
- Accepts single-beat writes and applies each to an on-chip word array, either as overwrite or as saturating signed read-modify-write accumulation.
- Used as the DRAM model and accumulation target in block and subsystem benches.
- Exposes a registered readback port and status counters.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words; power of two, at least 2.
- ADDR_LSB, 2, byte-offset bits; word index = dram_addr >> ADDR_LSB.
- STALL_BURST, 16, accepted beats between forced stalls (used only with GRAD_WR_STALL_EN).
- STALL_CYCLES, 4, cycles dram_ready is held low per stall (used only with GRAD_WR_STALL_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dram_valid  in  1  write beat valid.
- dram_addr  in  32  byte address.
- dram_value  in  32  signed write data.
- dram_ready  out  1  responder can accept a beat this cycle.
- accum_mode  in  1  0 = overwrite, 1 = saturating accumulate; sampled at accept.
- rd_en  in  1  readback request.
- rd_addr  in  32  readback byte address.
- rd_data  out  32  signed readback data.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- write_count  out  32  beats committed to memory; wraps.
- addr_err_count  out  16  beats dropped for bad address; saturates at 0xFFFF.
- sat_count  out  16  accumulations that clamped; saturates at 0xFFFF.
- busy  out  1  high while a beat is in flight (state RMW).

Behaviour:
- Reset values:
  - dram_ready=0, rd_data=0, rd_valid=0, busy=0, all counters 0, memory array cleared to 0, state IDLE.
  - dram_ready rises combinationally in IDLE from the first cycle after reset release.
- FSM states: IDLE and RMW.
- IDLE:
  - dram_ready=1 (unless stalled by the optional feature).
  - Accept occurs when dram_valid && dram_ready. On accept: latch addr, value and accum_mode, then go to RMW.
- RMW:
  - dram_ready=0 and busy=1. Read mem[idx], compute, write, return to IDLE.
  - Throughput is therefore one beat per 2 cycles. Memory is updated at the end of the RMW cycle.
- Address check:
  - A beat is bad if any of addr[ADDR_LSB-1:0] is nonzero (misaligned) or if (addr >> ADDR_LSB) >= MEM_DEPTH.
  - A bad beat still takes the RMW cycle. No memory write; addr_err_count +1; write_count unchanged.
- Overwrite mode: mem[idx] <= value.
- Accumulate mode:
  - 33-bit signed sum of mem[idx] + value.
  - If the sum > 0x7FFFFFFF, write 0x7FFFFFFF. If the sum < -2^31, write 0x80000000. Either clamp increments sat_count.
  - Otherwise write the sum.
- Every good beat increments write_count by 1; wraps at 2^32.
- Handshake: dram_addr, dram_value and accum_mode are sampled only at accept. dram_valid asserted while dram_ready=0 is held by the initiator and accepted later; no beat is lost or duplicated.
- Readback:
  - rd_en at cycle N gives rd_data = mem[rd_addr >> ADDR_LSB] and rd_valid=1 at cycle N+1.
  - If rd_en hits the same word that RMW writes in cycle N, the pre-write value is returned.
  - A bad rd_addr returns rd_data=0 with rd_valid=1 and does not count as an error.
  - rd_data holds its value when rd_valid=0.
- Reset mid-RMW: the in-flight beat is discarded (no write) and all state returns to reset values.

Optional Feature:
- GRAD_WR_STALL_EN defined:
  - A beat counter counts accepted beats. After every STALL_BURST accepts, dram_ready is forced low for STALL_CYCLES IDLE cycles, then the counter restarts.
  - Bad-address beats count toward the total.
  - The stall counter resets to 0.
  - Emulates DRAM row turnaround.
- Not defined: no stall logic; dram_ready = (state==IDLE).

Test Plan:
- Reset, then dram_valid=1, addr=0x10, value=5, accum_mode=0 -> accept at first IDLE cycle; busy=1 next cycle; read 0x10 returns 5; write_count=1.
- Accumulate: overwrite 0x20 with 100, then accumulate -30 and 7 at 0x20 -> readback 77; write_count=3; accept cycles spaced exactly 2 apart under continuous valid.
- Saturation: 0x7FFFFFF0 at 0x4, accumulate 0x100 -> 0x7FFFFFFF with sat_count=1; 0x80000000 plus -1 -> 0x80000000 with sat_count=2.
- Bad address: addr=0x3 then addr=MEM_DEPTH*4 -> addr_err_count=2; write_count unchanged; memory unchanged; readback of 0x400 gives rd_data=0, rd_valid=1.
- Hazard/reset: rd_en on 0x8 in the RMW cycle overwriting 0x8 from 1 to 9 -> rd_data=1, next read 9; assert rst_n=0 during RMW of 0xC -> 0xC reads 0 and counters are 0.
- With GRAD_WR_STALL_EN, STALL_BURST=4, STALL_CYCLES=3, 10 back-to-back beats -> dram_ready low 3 extra cycles after the 4th and 8th accepts; all 10 values committed in order.

Source files
------------

// File: rtl/gradient_dram_write_responder.sv
// Memory-side endpoint of the gradient writeback DRAM write channel: overwrite or saturating
// accumulate into an on-chip word array. Optional forced stalls when GRAD_WR_STALL_EN is defined.
module gradient_dram_write_responder #(
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned ADDR_LSB     = 2,
  parameter int unsigned STALL_BURST  = 16,
  parameter int unsigned STALL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dram_valid,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_value,
  output logic        dram_ready,
  input  logic        accum_mode,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] write_count,
  output logic [15:0] addr_err_count,
  output logic [15:0] sat_count,
  output logic        busy
);

  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);
  localparam logic [31:0] LsbMask = (32'd1 << ADDR_LSB) - 32'd1;
  localparam logic [31:0] Depth   = 32'(MEM_DEPTH);

  if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) ||
      (STALL_BURST == 0) || (STALL_CYCLES == 0)) begin : g_bad_cfg
    $error("gradient_dram_write_responder: illegal parameter combination");
  end

  typedef enum logic [0:0] {StIdle, StRmw} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [MEM_DEPTH];
  logic [31:0] addr_q, value_q;
  logic        accum_q;
  logic        stall;
  logic        accept;

  function automatic logic addr_bad(input logic [31:0] a);
    return ((a & LsbMask) != '0) || ((a >> ADDR_LSB) >= Depth);
  endfunction

  logic [IdxW-1:0] wr_idx, rd_idx;
  assign wr_idx = addr_q[ADDR_LSB +: IdxW];
  assign rd_idx = rd_addr[ADDR_LSB +: IdxW];

  always_comb begin
    state_d    = state_q;
    dram_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        dram_ready = rst_n & ~stall;
        if (dram_valid && dram_ready) state_d = StRmw;
      end
      StRmw: begin
        busy    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = (state_q == StIdle) & dram_ready & dram_valid;

  logic [31:0] old_val, new_val;
  logic [32:0] sum;
  logic        sat;
  logic        wr_bad;

  always_comb begin
    old_val = mem_q[wr_idx];
    sum     = {old_val[31], old_val} + {value_q[31], value_q};
    sat     = 1'b0;
    new_val = value_q;
    wr_bad  = addr_bad(addr_q);
    if (accum_q) begin
      new_val = sum[31:0];
      // Sign bits disagree only when the 33-bit sum left the 32-bit signed range.
      if (sum[32] != sum[31]) begin
        sat     = 1'b1;
        new_val = sum[32] ? 32'h8000_0000 : 32'h7fff_ffff;
      end
    end
  end

`ifdef GRAD_WR_STALL_EN
  logic [31:0] beat_cnt_q, stall_left_q;
  assign stall = (stall_left_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      stall_left_q <= '0;
    end else if (accept) begin
      if (beat_cnt_q == 32'(STALL_BURST - 1)) begin
        beat_cnt_q   <= '0;
        stall_left_q <= 32'(STALL_CYCLES);
      end else begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
    end else if ((state_q == StIdle) && stall) begin
      stall_left_q <= stall_left_q - 32'd1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      value_q        <= '0;
      accum_q        <= 1'b0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      write_count    <= '0;
      addr_err_count <= '0;
      sat_count      <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_valid <= rd_en;
      // Nonblocking read sees the pre-write value when it collides with the RMW write.
      if (rd_en) rd_data <= addr_bad(rd_addr) ? '0 : mem_q[rd_idx];
      if (accept) begin
        addr_q  <= dram_addr;
        value_q <= dram_value;
        accum_q <= accum_mode;
      end
      if (state_q == StRmw) begin
        if (wr_bad) begin
          if (addr_err_count != 16'hffff) addr_err_count <= addr_err_count + 16'd1;
        end else begin
          mem_q[wr_idx] <= new_val;
          write_count   <= write_count + 32'd1;
          if (sat && (sat_count != 16'hffff)) sat_count <= sat_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gradient_dram_write_responder.sv
// Directed self-checking bench for gradient_dram_write_responder; the stall section runs only
// when GRAD_WR_STALL_EN is defined.
module tb_gradient_dram_write_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dram_valid;
  logic [31:0] dram_addr;
  logic [31:0] dram_value;
  logic        dram_ready;
  logic        accum_mode;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] write_count;
  logic [15:0] addr_err_count;
  logic [15:0] sat_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gradient_dram_write_responder #(
    .MEM_DEPTH   (256),
    .ADDR_LSB    (2),
    .STALL_BURST (4),
    .STALL_CYCLES(3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dram_valid    (dram_valid),
    .dram_addr     (dram_addr),
    .dram_value    (dram_value),
    .dram_ready    (dram_ready),
    .accum_mode    (accum_mode),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .write_count   (write_count),
    .addr_err_count(addr_err_count),
    .sat_count     (sat_count),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge (RMW cycle).
  task automatic write_beat(input logic [31:0] a, input logic [31:0] v, input logic m,
                            input logic last, output int acc_cyc);
    int n = 0;
    dram_valid = 1'b1;
    dram_addr  = a;
    dram_value = v;
    accum_mode = m;
    while (!dram_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    if (last) dram_valid = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] a, input logic [31:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    int t0, a0, a1, a2;
    int acc [10];

    rst_n      = 1'b0;
    dram_valid = 1'b0;
    dram_addr  = '0;
    dram_value = '0;
    accum_mode = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(dram_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wcount", write_count, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(dram_ready), 32'd1);

    // First beat accepted in the first IDLE cycle.
    t0 = cyc;
    write_beat(32'h10, 32'd5, 1'b0, 1'b1, a0);
    check("first_accept_cyc", 32'(a0), 32'(t0));
    check("busy_in_rmw", 32'(busy), 32'd1);
    check("ready_in_rmw", 32'(dram_ready), 32'd0);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("wcount_1", write_count, 32'd1);
    read_word(32'h10, 32'd5, "rd_10");
    @(negedge clk);
    check("rd_valid_pulse", 32'(rd_valid), 32'd0);
    check("rd_data_hold", rd_data, 32'd5);

    // Continuous valid: overwrite then two accumulates, spaced 2 cycles.
    write_beat(32'h20, 32'd100, 1'b0, 1'b0, a0);
    write_beat(32'h20, 32'hffff_ffe2, 1'b1, 1'b0, a1);
    write_beat(32'h20, 32'd7, 1'b1, 1'b1, a2);
    check("spacing_01", 32'(a1 - a0), 32'd2);
    check("spacing_12", 32'(a2 - a1), 32'd2);
    @(negedge clk);
    check("wcount_4", write_count, 32'd4);
    read_word(32'h20, 32'd77, "rd_accum");

    // Saturation in both directions.
    write_beat(32'h4, 32'h7fff_fff0, 1'b0, 1'b1, a0);
    write_beat(32'h4, 32'h0000_0100, 1'b1, 1'b1, a0);
    @(negedge clk);
    check("sat_count_1", 32'(sat_count), 32'd1);
    read_word(32'h4, 32'h7fff_ffff, "rd_sat_pos");
    write_beat(32'h4, 32'h8000_0000, 1'b0, 1'b1, a0);
    write_beat(32'h4, 32'hffff_ffff, 1'b1, 1'b1, a0);
    @(negedge clk);
    check("sat_count_2", 32'(sat_count), 32'd2);
    check("wcount_8", write_count, 32'd8);
    read_word(32'h4, 32'h8000_0000, "rd_sat_neg");

    // Bad addresses: misaligned and out of range (both alias word 0).
    write_beat(32'h3, 32'h0000_dead, 1'b0, 1'b1, a0);
    write_beat(32'h400, 32'h0000_beef, 1'b0, 1'b1, a0);
    @(negedge clk);
    check("addr_err_2", 32'(addr_err_count), 32'd2);
    check("wcount_bad", write_count, 32'd8);
    read_word(32'h10, 32'd5, "rd_10_again");
    read_word(32'h0, 32'd0, "rd_word0");
    read_word(32'h10, 32'd5, "rd_10_third");
    read_word(32'h400, 32'd0, "rd_bad_addr");
    check("addr_err_rd", 32'(addr_err_count), 32'd2);

    // Read during the RMW that overwrites the same word returns the old value.
    write_beat(32'h8, 32'd1, 1'b0, 1'b1, a0);
    write_beat(32'h8, 32'd9, 1'b0, 1'b1, a0);
    read_word(32'h8, 32'd1, "rd_hazard");
    read_word(32'h8, 32'd9, "rd_after_hazard");
    check("wcount_10", write_count, 32'd10);

    // Reset during RMW discards the beat and clears everything.
    write_beat(32'hc, 32'h55, 1'b0, 1'b1, a0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wcount", write_count, 32'd0);
    check("rst_mid_sat", 32'(sat_count), 32'd0);
    check("rst_mid_err", 32'(addr_err_count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(dram_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("wcount_post_rst", write_count, 32'd0);
    read_word(32'hc, 32'd0, "rd_c_discarded");
    read_word(32'h20, 32'd0, "rd_20_cleared");

`ifdef GRAD_WR_STALL_EN
    // Ten back-to-back beats: extra 3-cycle gap after the 4th and 8th accepts.
    for (int k = 0; k < 10; k++) begin
      write_beat(32'h40 + 32'(4 * k), 32'(100 + k), 1'b0, 1'(k == 9), acc[k]);
    end
    for (int k = 1; k < 10; k++) begin
      check($sformatf("stall_gap_%0d", k), 32'(acc[k] - acc[k-1]),
            (k == 4 || k == 8) ? 32'd5 : 32'd2);
    end
    @(negedge clk);
    check("stall_wcount", write_count, 32'd10);
    for (int k = 0; k < 10; k++) begin
      read_word(32'h40 + 32'(4 * k), 32'(100 + k), $sformatf("stall_rd_%0d", k));
    end
`else
    acc[0] = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
